// File: rtl/id_branch_unit_pkg.sv
// Shared definitions for the ID-stage branch unit.
//   BR_OP_* : bit positions inside the one-hot br_op vector
//   br_state_e : redirect FSM state encoding
package id_branch_unit_pkg;

  localparam int BR_OP_W      = 12;
  localparam int BR_OP_J      = 0;
  localparam int BR_OP_JAL    = 1;
  localparam int BR_OP_JR     = 2;
  localparam int BR_OP_JALR   = 3;
  localparam int BR_OP_BEQ    = 4;
  localparam int BR_OP_BNE    = 5;
  localparam int BR_OP_BGEZ   = 6;
  localparam int BR_OP_BGTZ   = 7;
  localparam int BR_OP_BLEZ   = 8;
  localparam int BR_OP_BLTZ   = 9;
  localparam int BR_OP_BGEZAL = 10;
  localparam int BR_OP_BLTZAL = 11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_REDIRECT  = 2'd2
  } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   br_op   in  one-hot branch op
//   rs_data in  bypassed rs operand
//   rt_data in  bypassed rt operand
//   taken   out branch condition is true
// Sign tests use the operand MSB; REGIMM-class ops are masked when
// EN_REGIMM is 0.
module br_cond_eval
  import id_branch_unit_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int EN_REGIMM = 1
) (
  input  logic [BR_OP_W-1:0] br_op,
  input  logic [PC_W-1:0]    rs_data,
  input  logic [PC_W-1:0]    rt_data,
  output logic               taken
);

  localparam bit REGIMM_ON = (EN_REGIMM != 0);

  logic signed [PC_W-1:0] rs_s;
  logic                   rs_neg;
  logic                   rs_zero;
  logic                   rs_eq_rt;
  logic                   uncond;
  logic                   cmp_two;
  logic                   cmp_zero;

  assign rs_s     = signed'(rs_data);
  assign rs_neg   = rs_s[PC_W-1];
  assign rs_zero  = (rs_data == '0);
  assign rs_eq_rt = (rs_data == rt_data);

  assign uncond  = br_op[BR_OP_J] | br_op[BR_OP_JAL] | br_op[BR_OP_JR] | br_op[BR_OP_JALR];
  assign cmp_two = (br_op[BR_OP_BEQ] & rs_eq_rt) | (br_op[BR_OP_BNE] & ~rs_eq_rt);

  assign cmp_zero = ((br_op[BR_OP_BGEZ] | br_op[BR_OP_BGEZAL]) & ~rs_neg)
                  | (br_op[BR_OP_BGTZ] & ~rs_neg & ~rs_zero)
                  | (br_op[BR_OP_BLEZ] & (rs_neg | rs_zero))
                  | ((br_op[BR_OP_BLTZ] | br_op[BR_OP_BLTZAL]) & rs_neg);

  assign taken = uncond | cmp_two | (REGIMM_ON & cmp_zero);

endmodule

// File: rtl/id_branch_unit.sv
// ID-stage branch resolution and redirect unit.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   ds_fire, ds_pc       ID instruction handoff and its PC
//   br_op, target,       one-hot op, instr_index, branch immediate
//   offset
//   rs_data, rt_data     bypassed operands
//   slot_fetched         delay slot already held in IF or later
//   flush                exception/ERET flush, highest priority
//   br_valid, br_target, redirect request to IF and its handshake
//   br_ready
//   ds_br_stall          ID must hold a branch while a redirect is pending
//   link_we, link_addr   link register write and return address
//   cnt_taken,           saturating statistics counters
//   cnt_ntaken
module id_branch_unit
  import id_branch_unit_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16,
  parameter int EN_REGIMM = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ds_fire,
  input  logic [PC_W-1:0]    ds_pc,
  input  logic [BR_OP_W-1:0] br_op,
  input  logic [25:0]        target,
  input  logic [15:0]        offset,
  input  logic [PC_W-1:0]    rs_data,
  input  logic [PC_W-1:0]    rt_data,
  input  logic               slot_fetched,
  input  logic               flush,
  output logic               br_valid,
  output logic [PC_W-1:0]    br_target,
  input  logic               br_ready,
  output logic               ds_br_stall,
  output logic               link_we,
  output logic [PC_W-1:0]    link_addr,
  output logic [CNT_W-1:0]   cnt_taken,
  output logic [CNT_W-1:0]   cnt_ntaken
);

  localparam bit REGIMM_ON = (EN_REGIMM != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  br_state_e           state_q, state_d;
  logic [PC_W-1:0]     tgt_q, tgt_d;
  logic [CNT_W-1:0]    ct_q, ct_d;
  logic [CNT_W-1:0]    cn_q, cn_d;

  logic                taken;
  logic                is_br;
  logic                resolve;
  logic [PC_W-1:0]     pc_plus4;
  logic signed [15:0]  off_s;
  logic signed [PC_W-1:0] off_ext;
  logic [PC_W-1:0]     off_tgt;
  logic [PC_W-1:0]     j_tgt;
  logic [PC_W-1:0]     calc_tgt;

  br_cond_eval #(
    .PC_W      (PC_W),
    .EN_REGIMM (EN_REGIMM)
  ) u_cond (
    .br_op   (br_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .taken   (taken)
  );

  assign is_br    = |br_op;
  // A branch counts only when accepted in IDLE and not killed by flush.
  assign resolve  = ds_fire & is_br & (state_q == ST_IDLE) & ~flush;

  assign pc_plus4 = ds_pc + PC_W'(4);
  assign off_s    = signed'(offset);
  assign off_ext  = signed'({{(PC_W-18){off_s[15]}}, off_s, 2'b00});
  assign off_tgt  = pc_plus4 + $unsigned(off_ext);

  // Region bits above 27 come from the delay-slot PC; empty when PC_W is 28.
  always_comb begin
    j_tgt       = pc_plus4;
    j_tgt[27:0] = {target, 2'b00};
  end

  always_comb begin
    if (br_op[BR_OP_JR] | br_op[BR_OP_JALR]) begin
      calc_tgt = rs_data;
    end else if (br_op[BR_OP_J] | br_op[BR_OP_JAL]) begin
      calc_tgt = j_tgt;
    end else begin
      calc_tgt = off_tgt;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ct_d    = ct_q;
    cn_d    = cn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (resolve) begin
          if (taken) begin
            tgt_d   = calc_tgt;
            ct_d    = sat_inc(ct_q);
            state_d = slot_fetched ? ST_REDIRECT : ST_WAIT_SLOT;
          end else begin
            cn_d = sat_inc(cn_q);
          end
        end
      end
      ST_WAIT_SLOT: if (slot_fetched) state_d = ST_REDIRECT;
      ST_REDIRECT:  if (br_ready)     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Registered redirect state, target and counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      ct_q    <= '0;
      cn_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      ct_q    <= ct_d;
      cn_q    <= cn_d;
    end
  end

  assign br_valid    = (state_q == ST_REDIRECT);
  assign br_target   = tgt_q;
  assign ds_br_stall = is_br & (state_q != ST_IDLE);
  assign link_we     = ds_fire & (br_op[BR_OP_JAL] | br_op[BR_OP_JALR]
                     | (REGIMM_ON & (br_op[BR_OP_BGEZAL] | br_op[BR_OP_BLTZAL])));
  assign link_addr   = ds_pc + PC_W'(8);
  assign cnt_taken   = ct_q;
  assign cnt_ntaken  = cn_q;

endmodule

// File: tb/tb_id_branch_unit.sv
module tb_id_branch_unit;

  logic        clk = 1'b0;
  logic        resetn, ds_fire, slot_fetched, flush, br_ready;
  logic [31:0] ds_pc, rs_data, rt_data;
  logic [11:0] br_op;
  logic [25:0] target;
  logic [15:0] offset;

  logic        a_valid, a_stall, a_lwe;
  logic [31:0] a_tgt, a_laddr;
  logic [15:0] a_ct, a_cn;
  logic        b_valid, b_stall, b_lwe;
  logic [31:0] b_tgt, b_laddr;
  logic [15:0] b_ct, b_cn;
  logic        s_valid, s_stall, s_lwe;
  logic [31:0] s_tgt, s_laddr;
  logic [1:0]  s_ct, s_cn;

  int n_checks = 0;
  int n_err    = 0;

  int          m_ph[2];
  logic [31:0] m_tgt[2];
  int          m_ct[2];
  int          m_cn[2];

  always #5 clk = ~clk;

  id_branch_unit #(.PC_W(32), .CNT_W(16), .EN_REGIMM(1)) u_a (
    .clk(clk), .resetn(resetn), .ds_fire(ds_fire), .ds_pc(ds_pc), .br_op(br_op),
    .target(target), .offset(offset), .rs_data(rs_data), .rt_data(rt_data),
    .slot_fetched(slot_fetched), .flush(flush), .br_valid(a_valid), .br_target(a_tgt),
    .br_ready(br_ready), .ds_br_stall(a_stall), .link_we(a_lwe), .link_addr(a_laddr),
    .cnt_taken(a_ct), .cnt_ntaken(a_cn));

  id_branch_unit #(.PC_W(32), .CNT_W(16), .EN_REGIMM(0)) u_b (
    .clk(clk), .resetn(resetn), .ds_fire(ds_fire), .ds_pc(ds_pc), .br_op(br_op),
    .target(target), .offset(offset), .rs_data(rs_data), .rt_data(rt_data),
    .slot_fetched(slot_fetched), .flush(flush), .br_valid(b_valid), .br_target(b_tgt),
    .br_ready(br_ready), .ds_br_stall(b_stall), .link_we(b_lwe), .link_addr(b_laddr),
    .cnt_taken(b_ct), .cnt_ntaken(b_cn));

  id_branch_unit #(.PC_W(32), .CNT_W(2), .EN_REGIMM(1)) u_s (
    .clk(clk), .resetn(resetn), .ds_fire(ds_fire), .ds_pc(ds_pc), .br_op(br_op),
    .target(target), .offset(offset), .rs_data(rs_data), .rt_data(rt_data),
    .slot_fetched(slot_fetched), .flush(flush), .br_valid(s_valid), .br_target(s_tgt),
    .br_ready(br_ready), .ds_br_stall(s_stall), .link_we(s_lwe), .link_addr(s_laddr),
    .cnt_taken(s_ct), .cnt_ntaken(s_cn));

  // Reference: condition from signed arithmetic comparisons.
  function automatic bit ref_taken(input logic [11:0] op, input logic [31:0] rs,
                                   input logic [31:0] rt, input bit en);
    bit t;
    t = (op[3:0] != 4'b0);
    if (op[4] && rs == rt) t = 1;
    if (op[5] && rs != rt) t = 1;
    if (en) begin
      if ((op[6] || op[10]) && $signed(rs) >= 0) t = 1;
      if (op[7] && $signed(rs) > 0) t = 1;
      if (op[8] && $signed(rs) <= 0) t = 1;
      if ((op[9] || op[11]) && $signed(rs) < 0) t = 1;
    end
    return t;
  endfunction

  function automatic logic [31:0] ref_target(input logic [11:0] op, input logic [31:0] pc,
                                             input logic [25:0] ix, input logic [15:0] off,
                                             input logic [31:0] rs);
    logic [31:0] o;
    if (op[3:2] != 2'b0) return rs;
    if (op[1:0] != 2'b0) return ((pc + 32'd4) & 32'hF000_0000) | ({6'b0, ix} * 32'd4);
    o = 32'(int'($signed(off)) * 4);
    return pc + 32'd4 + o;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Phase 0 = idle, 1 = waiting for delay slot, 2 = redirect offered.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!resetn) begin
        m_ph[c] = 0; m_tgt[c] = '0; m_ct[c] = 0; m_cn[c] = 0;
      end else if (flush) begin
        m_ph[c] = 0;
      end else if (m_ph[c] == 0) begin
        if (ds_fire && br_op != 12'b0) begin
          if (ref_taken(br_op, rs_data, rt_data, c == 0)) begin
            m_tgt[c] = ref_target(br_op, ds_pc, target, offset, rs_data);
            m_ph[c]  = slot_fetched ? 2 : 1;
            m_ct[c]  = m_ct[c] + 1;
          end else begin
            m_cn[c] = m_cn[c] + 1;
          end
        end
      end else if (m_ph[c] == 1) begin
        if (slot_fetched) m_ph[c] = 2;
      end else if (br_ready) begin
        m_ph[c] = 0;
      end
    end
  end

  task automatic idle_inputs();
    ds_fire = 0; br_op = '0; flush = 0;
  endtask

  task automatic test_reset();
    resetn = 0; idle_inputs(); slot_fetched = 0; br_ready = 0;
    ds_pc = '0; rs_data = '0; rt_data = '0; target = '0; offset = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b exp 0", a_valid); end
    n_checks++; if (a_tgt !== 32'h0) begin n_err++; $display("FAIL rst_target: got %h exp 0", a_tgt); end
    n_checks++; if (a_ct !== 16'd0 || a_cn !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", a_ct, a_cn); end
    n_checks++; if (a_stall !== 1'b0 || a_lwe !== 1'b0) begin n_err++; $display("FAIL rst_stall_lwe: got %0b/%0b exp 0/0", a_stall, a_lwe); end
    br_op = 12'h001; #1;
    n_checks++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_idle: got %0b exp 0", a_stall); end
    @(negedge clk); resetn = 1; idle_inputs();
  endtask

  task automatic test_beq();
    @(negedge clk);
    ds_fire = 1; br_op = 12'h010; ds_pc = 32'hBFC0_0010; offset = 16'hFFFC;
    rs_data = 32'd5; rt_data = 32'd5; slot_fetched = 1; br_ready = 1; #1;
    n_checks++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL beq_early: got %0b exp 0", a_valid); end
    n_checks++; if (a_lwe !== 1'b0 || a_laddr !== 32'hBFC0_0018) begin n_err++; $display("FAIL beq_link: got %0b %h exp 0 bfc00018", a_lwe, a_laddr); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid: got %0b exp 1", a_valid); end
    n_checks++; if (a_tgt !== 32'hBFC0_0004) begin n_err++; $display("FAIL beq_target: got %h exp bfc00004", a_tgt); end
    n_checks++; if (a_ct !== 16'd1 || a_cn !== 16'd0) begin n_err++; $display("FAIL beq_cnt: got %0d/%0d exp 1/0", a_ct, a_cn); end
    @(negedge clk); #1;
    n_checks++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL beq_drop: got %0b exp 0", a_valid); end
  endtask

  task automatic test_bltzal();
    @(negedge clk);
    ds_fire = 1; br_op = 12'h800; ds_pc = 32'h0040_0000; rs_data = 32'h1; rt_data = 32'h0;
    slot_fetched = 1; br_ready = 1; #1;
    n_checks++; if (a_lwe !== 1'b1 || a_laddr !== 32'h0040_0008) begin n_err++; $display("FAIL bltzal_link: got %0b %h exp 1 00400008", a_lwe, a_laddr); end
    n_checks++; if (b_lwe !== 1'b0) begin n_err++; $display("FAIL bltzal_nolink_noregimm: got %0b exp 0", b_lwe); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (a_valid !== 1'b0 || a_cn !== 16'd1) begin n_err++; $display("FAIL bltzal_nt: got v=%0b cn=%0d exp v=0 cn=1", a_valid, a_cn); end
    @(negedge clk);
    ds_fire = 1; br_op = 12'h800; rs_data = 32'h8000_0000; #1;
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (a_valid !== 1'b1 || a_ct !== 16'd2) begin n_err++; $display("FAIL bltzal_t: got v=%0b ct=%0d exp v=1 ct=2", a_valid, a_ct); end
    n_checks++; if (b_valid !== 1'b0 || b_cn !== 16'd2) begin n_err++; $display("FAIL bltzal_noregimm: got v=%0b cn=%0d exp v=0 cn=2", b_valid, b_cn); end
    @(negedge clk);
  endtask

  task automatic test_jr_wait();
    @(negedge clk);
    ds_fire = 1; br_op = 12'h004; rs_data = 32'h8000_1234; slot_fetched = 0; br_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ds_fire = 0; slot_fetched = (i == 2); #1;
      n_checks++; if (a_valid !== 1'b0 || a_stall !== 1'b1) begin n_err++; $display("FAIL jr_wait%0d: got v=%0b st=%0b exp 0/1", i, a_valid, a_stall); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); slot_fetched = 0; br_ready = (i == 2); #1;
      n_checks++; if (a_valid !== 1'b1 || a_tgt !== 32'h8000_1234) begin n_err++; $display("FAIL jr_redirect%0d: got v=%0b %h exp 1 80001234", i, a_valid, a_tgt); end
    end
    @(negedge clk); br_ready = 0; #1;
    n_checks++; if (a_valid !== 1'b0 || a_stall !== 1'b0) begin n_err++; $display("FAIL jr_done: got v=%0b st=%0b exp 0/0", a_valid, a_stall); end
    idle_inputs();
  endtask

  task automatic test_flush();
    int ct, cn;
    ct = m_ct[0]; cn = m_cn[0];
    @(negedge clk);
    ds_fire = 1; br_op = 12'h001; ds_pc = 32'h1000_0FFC; target = 26'h0123456;
    slot_fetched = 1; br_ready = 0; flush = 1; #1;
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (a_valid !== 1'b0 || a_ct !== 16'(ct) || a_cn !== 16'(cn)) begin n_err++; $display("FAIL flush_resolve: got v=%0b %0d/%0d exp 0 %0d/%0d", a_valid, a_ct, a_cn, ct, cn); end
    ds_fire = 1; br_op = 12'h001;
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (a_valid !== 1'b1 || a_tgt !== 32'h1048_D158) begin n_err++; $display("FAIL j_target: got v=%0b %h exp 1 1048d158", a_valid, a_tgt); end
    flush = 1;
    @(negedge clk); flush = 0; #1;
    n_checks++; if (a_valid !== 1'b0 || a_ct !== 16'(ct + 1)) begin n_err++; $display("FAIL flush_redirect: got v=%0b ct=%0d exp 0 %0d", a_valid, a_ct, ct + 1); end
  endtask

  task automatic test_back_to_back();
    int ct;
    ct = m_ct[0];
    @(negedge clk);
    ds_fire = 1; br_op = 12'h010; ds_pc = 32'h100; offset = 16'h0010;
    rs_data = 32'd7; rt_data = 32'd7; slot_fetched = 1; br_ready = 0;
    @(negedge clk); br_op = 12'h001; target = 26'h3FF_FFFF; #1;
    n_checks++; if (a_valid !== 1'b1 || a_stall !== 1'b1 || a_tgt !== 32'h144) begin n_err++; $display("FAIL stall_hold: got v=%0b st=%0b %h exp 1 1 00000144", a_valid, a_stall, a_tgt); end
    @(negedge clk); br_ready = 1; #1;
    n_checks++; if (a_tgt !== 32'h144 || a_ct !== 16'(ct + 1)) begin n_err++; $display("FAIL stall_ignore: got %h ct=%0d exp 00000144 %0d", a_tgt, a_ct, ct + 1); end
    @(negedge clk);
    br_op = 12'h020; rs_data = 32'd1; rt_data = 32'd2; ds_pc = 32'h200; offset = 16'hFFFF; #1;
    n_checks++; if (a_valid !== 1'b0 || a_stall !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got v=%0b st=%0b exp 0/0", a_valid, a_stall); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (a_valid !== 1'b1 || a_tgt !== 32'h200 || a_ct !== 16'(ct + 2)) begin n_err++; $display("FAIL b2b_bne: got v=%0b %h ct=%0d exp 1 00000200 %0d", a_valid, a_tgt, a_ct, ct + 2); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    @(negedge clk); resetn = 0; idle_inputs();
    @(negedge clk); resetn = 1;
    for (int i = 0; i < 5; i++) begin
      ds_fire = 1; br_op = 12'h001; ds_pc = 32'h0; target = 26'(i); slot_fetched = 1; br_ready = 1;
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (s_ct !== 2'(sat(i + 1, 3)) || a_ct !== 16'(i + 1)) begin n_err++; $display("FAIL sat%0d: got %0d/%0d exp %0d/%0d", i, s_ct, a_ct, sat(i + 1, 3), i + 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 12);
      br_op   = (r == 12) ? 12'b0 : (12'b1 << r);
      ds_fire = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      slot_fetched = $urandom_range(0, 1);
      br_ready     = $urandom_range(0, 1);
      ds_pc  = $urandom; target = 26'($urandom); offset = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rs_data = 32'h0;
        1: rs_data = $urandom | 32'h8000_0000;
        2: rs_data = $urandom & 32'h7FFF_FFFF;
        default: rs_data = $urandom;
      endcase
      rt_data = $urandom_range(0, 1) ? rs_data : $urandom;
      #1;
      n_checks++;
      if (a_valid !== (m_ph[0] == 2) || a_tgt !== m_tgt[0] || a_stall !== (br_op != 0 && m_ph[0] != 0)
          || a_ct !== 16'(m_ct[0]) || a_cn !== 16'(m_cn[0])) begin
        n_err++; $display("FAIL rnd_a%0d: got v=%0b %h st=%0b %0d/%0d exp v=%0b %h ph=%0d %0d/%0d",
          n, a_valid, a_tgt, a_stall, a_ct, a_cn, m_ph[0] == 2, m_tgt[0], m_ph[0], m_ct[0], m_cn[0]);
      end
      n_checks++;
      if (b_valid !== (m_ph[1] == 2) || b_tgt !== m_tgt[1] || b_stall !== (br_op != 0 && m_ph[1] != 0)
          || b_ct !== 16'(m_ct[1]) || b_cn !== 16'(m_cn[1])) begin
        n_err++; $display("FAIL rnd_b%0d: got v=%0b %h st=%0b %0d/%0d exp v=%0b %h ph=%0d %0d/%0d",
          n, b_valid, b_tgt, b_stall, b_ct, b_cn, m_ph[1] == 2, m_tgt[1], m_ph[1], m_ct[1], m_cn[1]);
      end
      n_checks++;
      if (a_lwe !== (ds_fire && (br_op[1] || br_op[3] || br_op[10] || br_op[11]))
          || b_lwe !== (ds_fire && (br_op[1] || br_op[3])) || a_laddr !== ds_pc + 32'd8 || b_laddr !== ds_pc + 32'd8) begin
        n_err++; $display("FAIL rnd_link%0d: got %0b %0b %h exp op=%h fire=%0b pc+8=%h", n, a_lwe, b_lwe, a_laddr, br_op, ds_fire, ds_pc + 32'd8);
      end
      n_checks++;
      if (s_valid !== (m_ph[0] == 2) || s_tgt !== m_tgt[0] || s_stall !== a_stall || s_lwe !== a_lwe || s_laddr !== a_laddr
          || s_ct !== 2'(sat(m_ct[0], 3)) || s_cn !== 2'(sat(m_cn[0], 3))) begin
        n_err++; $display("FAIL rnd_sat%0d: got v=%0b %h %0d/%0d exp v=%0b %h %0d/%0d",
          n, s_valid, s_tgt, s_ct, s_cn, m_ph[0] == 2, m_tgt[0], sat(m_ct[0], 3), sat(m_cn[0], 3));
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle_inputs();
    ds_fire = 1; br_op = 12'h004; rs_data = 32'hDEAD_BEE0; slot_fetched = 1; br_ready = 0;
    @(negedge clk); idle_inputs(); resetn = 0; #1;
    n_checks++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got %0b exp 1", a_valid); end
    @(negedge clk); #1;
    n_checks++; if (a_valid !== 1'b0 || a_tgt !== 32'h0 || a_ct !== 16'd0) begin n_err++; $display("FAIL rstmid_post: got v=%0b %h ct=%0d exp 0 0 0", a_valid, a_tgt, a_ct); end
    resetn = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bltzal();
    test_jr_wait();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
